// File: rtl/tmp2_sampler.sv
// -----------------------------------------------------------------------------
// tmp2_sampler
// Control stage for the Pmod TMP2 interface. Periodically (or on demand)
// requests a temperature read, waits for the interface to finish it,
// normalises the reading to signed 1/128 degC and keeps min/max/count
// statistics plus high/low threshold alarms.
//
// Optional feature: define TMP2_SAMPLER_AVG_EN to build the exponential
// average on avg_o; without it avg_o is tied to zero.
//
// Ports:
//   clk, rst            system clock, synchronous active-low reset
//   enable              1 = periodic sampling runs
//   sample_now          one-cycle pulse, request a sample immediately (IDLE only)
//   clear_stats         one-cycle pulse, clear min/max/count/avg
//   resolution          1 = 16-bit sensor mode, 0 = 13-bit mode
//   busy_i, valid_i,
//   temperature_i       from the TMP2 interface
//   high_thr, low_thr   signed alarm thresholds, 1/128 degC
//   update_o            request strobe to the TMP2 interface
//   temp_o, temp_valid  last temperature and its one-cycle update strobe
//   min_o, max_o, avg_o statistics since clear
//   sample_count        samples since clear, saturating
//   alarm_high/low      last temp_o above high_thr / below low_thr
//   timeout_o           sticky, a request timed out
//   retry_o             one-cycle strobe when a request is re-issued
// -----------------------------------------------------------------------------
module tmp2_sampler #(
    parameter int unsigned PERIOD_CYCLES  = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned AVG_LOG2       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sample_now,
    input  logic        clear_stats,
    input  logic        resolution,
    input  logic        busy_i,
    input  logic        valid_i,
    input  logic [15:0] temperature_i,
    input  logic [15:0] high_thr,
    input  logic [15:0] low_thr,
    output logic        update_o,
    output logic [15:0] temp_o,
    output logic        temp_valid,
    output logic [15:0] min_o,
    output logic [15:0] max_o,
    output logic [15:0] avg_o,
    output logic [15:0] sample_count,
    output logic        alarm_high,
    output logic        alarm_low,
    output logic        timeout_o,
    output logic        retry_o
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DATA_W = 16;

    localparam logic [CNT_W-1:0]  PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] MIN_INIT     = 16'h7FFF;
    localparam logic [DATA_W-1:0] MAX_INIT     = 16'h8000;
    localparam logic [DATA_W-1:0] COUNT_MAX    = 16'hFFFF;

    // Elaboration-time sanity check on the configuration.
    if (PERIOD_CYCLES < 16 || AVG_LOG2 > 15) begin : g_bad_param
        $error("tmp2_sampler: PERIOD_CYCLES must be >= 16 and AVG_LOG2 <= 15");
    end

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REQ        = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DATA  = 3'd3,
        CAPTURE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]    timeout_cnt_q, timeout_cnt_d;
    logic                valid_prev_q, valid_prev_d;
    logic                update_q, update_d;
    logic                timeout_q, timeout_d;
    logic                retry_q, retry_d;
    logic                temp_valid_q, temp_valid_d;
    logic [DATA_W-1:0]   temp_q, temp_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [DATA_W-1:0]   count_q, count_d;
    logic                alarm_high_q, alarm_high_d;
    logic                alarm_low_q, alarm_low_d;

    logic [DATA_W-1:0]   sample_new;
    logic                timed_out;

    // Reading normalised to 1/128 degC; 13-bit mode clears the flag bits.
    assign sample_new = resolution ? temperature_i : {temperature_i[15:3], 3'b000};

    // Request phases share one watchdog; it expires on the last allowed cycle.
    assign timed_out = ((state_q == REQ) || (state_q == WAIT_START) || (state_q == WAIT_DATA))
                       && (timeout_cnt_q == TIMEOUT_LAST);

    // Sequencer: next state, counters, handshake strobes.
    always_comb begin
        state_d       = state_q;
        period_cnt_d  = '0;
        timeout_cnt_d = timeout_cnt_q;
        timeout_d     = timeout_q;
        retry_d       = 1'b0;
        temp_valid_d  = 1'b0;
        valid_prev_d  = valid_i;

        unique case (state_q)
            IDLE: begin
                if (sample_now || (enable && (period_cnt_q == PERIOD_LAST))) begin
                    state_d       = REQ;
                    timeout_cnt_d = '0;
                end else if (enable) begin
                    period_cnt_d = period_cnt_q + CNT_W'(1);
                end
            end
            REQ: begin
                timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                if (timed_out) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (busy_i) begin
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                if (timed_out) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (!valid_i) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                if (timed_out) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (!valid_prev_q && valid_i) begin
                    state_d = CAPTURE;
                end else if (!busy_i && !valid_i) begin
                    // Interface finished without data: it was a config write.
                    retry_d = 1'b1;
                    state_d = REQ;
                end
            end
            CAPTURE: begin
                temp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // update_o is high for every cycle spent in REQ.
    assign update_d = (state_d == REQ);

    // Sample, statistics and alarm update.
    always_comb begin
        temp_d       = temp_q;
        min_d        = min_q;
        max_d        = max_q;
        count_d      = count_q;
        alarm_high_d = alarm_high_q;
        alarm_low_d  = alarm_low_q;

        if (state_q == CAPTURE) begin
            temp_d       = sample_new;
            alarm_high_d = $signed(sample_new) > $signed(high_thr);
            alarm_low_d  = $signed(sample_new) < $signed(low_thr);
            if (clear_stats) begin
                // Clear and capture together: the new sample seeds the stats.
                min_d   = sample_new;
                max_d   = sample_new;
                count_d = 16'd1;
            end else begin
                if ($signed(sample_new) < $signed(min_q)) begin
                    min_d = sample_new;
                end
                if ($signed(sample_new) > $signed(max_q)) begin
                    max_d = sample_new;
                end
                if (count_q != COUNT_MAX) begin
                    count_d = count_q + 16'd1;
                end
            end
        end else if (clear_stats) begin
            min_d   = MIN_INIT;
            max_d   = MAX_INIT;
            count_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            period_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            valid_prev_q  <= 1'b0;
            update_q      <= 1'b0;
            timeout_q     <= 1'b0;
            retry_q       <= 1'b0;
            temp_valid_q  <= 1'b0;
            temp_q        <= '0;
            min_q         <= MIN_INIT;
            max_q         <= MAX_INIT;
            count_q       <= '0;
            alarm_high_q  <= 1'b0;
            alarm_low_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            valid_prev_q  <= valid_prev_d;
            update_q      <= update_d;
            timeout_q     <= timeout_d;
            retry_q       <= retry_d;
            temp_valid_q  <= temp_valid_d;
            temp_q        <= temp_d;
            min_q         <= min_d;
            max_q         <= max_d;
            count_q       <= count_d;
            alarm_high_q  <= alarm_high_d;
            alarm_low_q   <= alarm_low_d;
        end
    end

`ifdef TMP2_SAMPLER_AVG_EN
    logic [DATA_W-1:0]   avg_q, avg_d;
    logic signed [16:0]  avg_diff;
    logic signed [16:0]  avg_step;
    logic signed [16:0]  avg_sum;

    // Exponential average in 17-bit signed arithmetic; the sum always lies
    // between old average and new sample, so truncation to 16 bits is exact.
    always_comb begin
        avg_diff = $signed({sample_new[15], sample_new}) - $signed({avg_q[15], avg_q});
        avg_step = avg_diff >>> AVG_LOG2;
        avg_sum  = $signed({avg_q[15], avg_q}) + avg_step;
        avg_d    = avg_q;
        if (state_q == CAPTURE) begin
            if (clear_stats || (count_q == '0)) begin
                avg_d = sample_new;
            end else begin
                avg_d = 16'(avg_sum);
            end
        end else if (clear_stats) begin
            avg_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            avg_q <= '0;
        end else begin
            avg_q <= avg_d;
        end
    end

    assign avg_o = avg_q;
`else
    assign avg_o = '0;
`endif

    assign update_o     = update_q;
    assign temp_o       = temp_q;
    assign temp_valid   = temp_valid_q;
    assign min_o        = min_q;
    assign max_o        = max_q;
    assign sample_count = count_q;
    assign alarm_high   = alarm_high_q;
    assign alarm_low    = alarm_low_q;
    assign timeout_o    = timeout_q;
    assign retry_o      = retry_q;

endmodule

// File: tb/tb_tmp2_sampler.sv
// -----------------------------------------------------------------------------
// tb_tmp2_sampler
// Directed bench for tmp2_sampler with a small TMP2 interface responder.
// A table of read transactions with hand-computed results, plus hand-written
// sequences for periodic timing, timeout, and the average.
// -----------------------------------------------------------------------------
module tb_tmp2_sampler;

    localparam int unsigned PERIOD = 100;
    localparam int unsigned TMO    = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sample_now;
    logic        clear_stats;
    logic        resolution;
    logic        busy_i;
    logic        valid_i;
    logic [15:0] temperature_i;
    logic [15:0] high_thr;
    logic [15:0] low_thr;
    logic        update_o;
    logic [15:0] temp_o;
    logic        temp_valid;
    logic [15:0] min_o;
    logic [15:0] max_o;
    logic [15:0] avg_o;
    logic [15:0] sample_count;
    logic        alarm_high;
    logic        alarm_low;
    logic        timeout_o;
    logic        retry_o;

    int n_tests = 0;
    int n_fail  = 0;

    tmp2_sampler #(
        .PERIOD_CYCLES (PERIOD),
        .TIMEOUT_CYCLES(TMO),
        .AVG_LOG2      (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_now   (sample_now),
        .clear_stats  (clear_stats),
        .resolution   (resolution),
        .busy_i       (busy_i),
        .valid_i      (valid_i),
        .temperature_i(temperature_i),
        .high_thr     (high_thr),
        .low_thr      (low_thr),
        .update_o     (update_o),
        .temp_o       (temp_o),
        .temp_valid   (temp_valid),
        .min_o        (min_o),
        .max_o        (max_o),
        .avg_o        (avg_o),
        .sample_count (sample_count),
        .alarm_high   (alarm_high),
        .alarm_low    (alarm_low),
        .timeout_o    (timeout_o),
        .retry_o      (retry_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        res;
        logic [15:0] raw;
        logic [15:0] hi;
        logic [15:0] lo;
        bit          clr;
        bit          cfg;
        logic [15:0] e_temp;
        logic [15:0] e_min;
        logic [15:0] e_max;
        logic [15:0] e_cnt;
        logic        e_ah;
        logic        e_al;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {15'd0, act}, {15'd0, exp});
    endtask

    // Bounded wait for the request strobe.
    task automatic wait_update();
        int n;
        n = 0;
        while (update_o !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check1("wait_update", update_o, 1'b1);
    endtask

    // TMP2 interface model. Returns on the cycle temp_valid should be high.
    task automatic run_read(input logic [15:0] raw, input bit clr, input bit cfg, input bit now);
        if (now) begin
            sample_now = 1'b1;
            @(negedge clk);
            sample_now = 1'b0;
        end
        wait_update();
        repeat (5) @(negedge clk);
        check1("update_held", update_o, 1'b1);
        busy_i  = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        check1("update_drop", update_o, 1'b0);
        if (cfg) begin
            @(negedge clk);
            busy_i = 1'b0;                 // config write ends with no data
            @(negedge clk);
            check1("retry_pulse", retry_o, 1'b1);
            check1("retry_rereq", update_o, 1'b1);
            @(negedge clk);
            check1("retry_single", retry_o, 1'b0);
            busy_i = 1'b1;
            repeat (4) @(negedge clk);
        end else begin
            repeat (3) @(negedge clk);
        end
        temperature_i = raw;
        valid_i       = 1'b1;
        busy_i        = 1'b0;
        @(negedge clk);                    // DUT is in CAPTURE now
        if (clr) clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        check1("temp_valid", temp_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        res   raw       hi        lo        clr cfg temp      min       max       cnt   ah    al
        vecs[0] = '{1'b0, 16'hFF87, 16'h7FFF, 16'h0000, 0, 0, 16'hFF80, 16'hFF80, 16'hFF80, 16'd1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 16'h0C80, 16'h0C80, 16'h0C80, 0, 0, 16'h0C80, 16'hFF80, 16'h0C80, 16'd2, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h0C87, 16'h0C7F, 16'h0000, 0, 0, 16'h0C80, 16'hFF80, 16'h0C80, 16'd3, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 16'h0800, 16'h7FFF, 16'h8000, 0, 1, 16'h0800, 16'hFF80, 16'h0C80, 16'd4, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h2000, 16'h7FFF, 16'h8000, 0, 0, 16'h2000, 16'hFF80, 16'h2000, 16'd5, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h1000, 16'h7FFF, 16'h8000, 1, 0, 16'h1000, 16'h1000, 16'h1000, 16'd1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h8000, 16'h8000, 16'h8001, 0, 0, 16'h8000, 16'h8000, 16'h1000, 16'd2, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 16'h7FFF, 16'h7FF0, 16'h8000, 0, 0, 16'h7FF8, 16'h8000, 16'h7FF8, 16'd3, 1'b1, 1'b0};

        rst           = 1'b0;
        enable        = 1'b1;
        sample_now    = 1'b0;
        clear_stats   = 1'b0;
        resolution    = 1'b1;
        busy_i        = 1'b0;
        valid_i       = 1'b1;
        temperature_i = 16'h0000;
        high_thr      = 16'h7FFF;
        low_thr       = 16'h8000;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_temp", temp_o, 16'h0000);
        check("rst_min", min_o, 16'h7FFF);
        check("rst_max", max_o, 16'h8000);
        check("rst_count", sample_count, 16'h0000);
        check("rst_avg", avg_o, 16'h0000);
        check1("rst_update", update_o, 1'b0);
        check1("rst_timeout", timeout_o, 1'b0);
        check1("rst_alarms", alarm_high | alarm_low, 1'b0);
        rst = 1'b1;

        // Periodic request fires PERIOD cycles after reset release
        repeat (PERIOD - 1) @(negedge clk);
        check1("period_early", update_o, 1'b0);
        @(negedge clk);
        check1("period_req", update_o, 1'b1);
        run_read(16'h0C80, 0, 0, 0);
        check("t1_temp", temp_o, 16'h0C80);
        check("t1_min", min_o, 16'h0C80);
        check("t1_max", max_o, 16'h0C80);
        check("t1_count", sample_count, 16'd1);
        repeat (PERIOD - 1) @(negedge clk);
        check1("period2_early", update_o, 1'b0);
        @(negedge clk);
        check1("period2_req", update_o, 1'b1);
        enable = 1'b0;                     // request must still complete
        run_read(16'h0C80, 0, 0, 0);
        check("t1_count2", sample_count, 16'd2);

        // clear_stats outside CAPTURE restores reset stats only
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        @(negedge clk);
        check("clr_min", min_o, 16'h7FFF);
        check("clr_max", max_o, 16'h8000);
        check("clr_count", sample_count, 16'd0);
        check("clr_temp_kept", temp_o, 16'h0C80);

        // Table of read transactions
        for (int i = 0; i < 8; i++) begin
            resolution = vecs[i].res;
            high_thr   = vecs[i].hi;
            low_thr    = vecs[i].lo;
            run_read(vecs[i].raw, vecs[i].clr, vecs[i].cfg, 1);
            check($sformatf("v%0d_temp", i), temp_o, vecs[i].e_temp);
            check($sformatf("v%0d_min", i), min_o, vecs[i].e_min);
            check($sformatf("v%0d_max", i), max_o, vecs[i].e_max);
            check($sformatf("v%0d_count", i), sample_count, vecs[i].e_cnt);
            check1($sformatf("v%0d_alarm_high", i), alarm_high, vecs[i].e_ah);
            check1($sformatf("v%0d_alarm_low", i), alarm_low, vecs[i].e_al);
`ifndef TMP2_SAMPLER_AVG_EN
            check($sformatf("v%0d_avg_tied", i), avg_o, 16'h0000);
`endif
            @(negedge clk);
            check1($sformatf("v%0d_strobe_end", i), temp_valid, 1'b0);
        end

        // Timeout: nobody answers the request
        sample_now = 1'b1;
        @(negedge clk);
        sample_now = 1'b0;
        check1("tmo_req", update_o, 1'b1);
        repeat (TMO - 1) @(negedge clk);
        check1("tmo_early", timeout_o, 1'b0);
        @(negedge clk);
        check1("tmo_set", timeout_o, 1'b1);
        check1("tmo_update", update_o, 1'b0);
        check("tmo_count", sample_count, 16'd3);
        enable = 1'b1;
        repeat (PERIOD - 1) @(negedge clk);
        check1("tmo_next_early", update_o, 1'b0);
        @(negedge clk);
        check1("tmo_next_req", update_o, 1'b1);
        resolution = 1'b1;
        run_read(16'h0100, 0, 0, 0);
        enable = 1'b0;
        check("tmo_after_temp", temp_o, 16'h0100);
        check("tmo_after_count", sample_count, 16'd4);
        check1("tmo_sticky", timeout_o, 1'b1);

        // Average: samples 0x0000 then 0x0400 after a clear
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        @(negedge clk);
        check("avg_clr", avg_o, 16'h0000);
        run_read(16'h0000, 0, 0, 1);
        check("avg_first", avg_o, 16'h0000);
        @(negedge clk);
        run_read(16'h0400, 0, 0, 1);
`ifdef TMP2_SAMPLER_AVG_EN
        check("avg_second", avg_o, 16'h0080);
`else
        check("avg_second", avg_o, 16'h0000);
`endif
        check("avg_count", sample_count, 16'd2);
        check("avg_max", max_o, 16'h0400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
